// File: rtl/fir_sched_pkg.sv
// Shared constants and state encoding for the FIR coefficient scheduler.
package fir_sched_pkg;

    localparam int WIDTH         = 18;
    localparam int NTAPS         = 61;
    localparam int ADDR_W        = 6;
    localparam int FLUSH_SAMPLES = 128;
    localparam int FLUSH_W       = $clog2(FLUSH_SAMPLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        FLUSH = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sam_en_gen.sv
// Free-running sample-rate divider: one registered enable pulse every DIV
// sys_clk cycles, independent of any scheduler state.
module sam_en_gen #(
    parameter int DIV = 4
) (
    input  logic sys_clk,
    input  logic reset,
    output logic sam_clk_en
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            div_cnt    <= '0;
            sam_clk_en <= 1'b0;
        end else begin
            sam_clk_en <= (div_cnt == LAST);
            div_cnt    <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fir_coef_sched.sv
// Coefficient loader and bank-swap controller for the folded 121-tap FIR:
// streams a set into the shadow bank, swaps on a sample boundary, then
// masks out_valid until the pipeline has flushed.
module fir_coef_sched #(
    parameter int WIDTH         = fir_sched_pkg::WIDTH,
    parameter int NTAPS         = fir_sched_pkg::NTAPS,
    parameter int ADDR_W        = fir_sched_pkg::ADDR_W,
    parameter int DIV           = 4,
    parameter int FLUSH_SAMPLES = fir_sched_pkg::FLUSH_SAMPLES
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]  cfg_data,
    input  logic              cfg_last,
    output logic              sam_clk_en,
    output logic              coef_wr_en,
    output logic [ADDR_W-1:0] coef_wr_addr,
    output logic [WIDTH-1:0]  coef_wr_data,
    output logic              bank_sel,
    output logic              out_valid,
    output logic              busy,
    output logic              cfg_err
);

    import fir_sched_pkg::*;

    localparam int FW_MIN = $clog2(FLUSH_SAMPLES + 1);
    localparam int FW     = (FLUSH_W > FW_MIN) ? FLUSH_W : FW_MIN;
    localparam logic [FW-1:0]     FLUSH_INIT = FW'(FLUSH_SAMPLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NTAPS - 1);

    sched_state_t      state;
    logic [ADDR_W-1:0] beat_cnt;
    logic [FW-1:0]     flush_cnt;
    logic              accept;
    logic              beat_ok;

    sam_en_gen #(.DIV(DIV)) u_sam_en (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en)
    );

    assign cfg_ready = (state == IDLE) || (state == LOAD);
    assign busy      = (state != IDLE);
    assign accept    = cfg_valid && cfg_ready;

    // A set must start at 0, arrive in order, and carry last exactly on the final tap.
    always_comb begin
        beat_ok = 1'b0;
        if (state == IDLE) begin
            beat_ok = (cfg_addr == '0);
        end else begin
            beat_ok = (cfg_addr == beat_cnt) && (cfg_last == (cfg_addr == LAST_ADDR));
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state        <= FLUSH;
            flush_cnt    <= FLUSH_INIT;
            beat_cnt     <= '0;
            bank_sel     <= 1'b0;
            out_valid    <= 1'b0;
            cfg_err      <= 1'b0;
            coef_wr_en   <= 1'b0;
            coef_wr_addr <= '0;
            coef_wr_data <= '0;
        end else begin
            coef_wr_en <= accept && beat_ok;
            cfg_err    <= accept && !beat_ok;
            if (accept && beat_ok) begin
                coef_wr_addr <= cfg_addr;
                coef_wr_data <= cfg_data;
            end

            case (state)
                IDLE: begin
                    if (accept && beat_ok) begin
                        state    <= LOAD;
                        beat_cnt <= ADDR_W'(1);
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (!beat_ok) begin
                            state <= IDLE;
                        end else if (cfg_last) begin
                            state <= ARMED;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                // Swapping on the enable edge means the very next sample uses the new set.
                ARMED: begin
                    if (sam_clk_en) begin
                        bank_sel  <= ~bank_sel;
                        out_valid <= 1'b0;
                        flush_cnt <= FLUSH_INIT;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (sam_clk_en) begin
                        flush_cnt <= flush_cnt - 1'b1;
                        if (flush_cnt == FW'(1)) begin
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_sched.sv
// Randomized scoreboard bench for fir_coef_sched against a flag-based
// behavioural model of the load / swap / flush rules.
module tb_fir_coef_sched;

    localparam int DIV           = 4;
    localparam int NTAPS         = 61;
    localparam int FLUSH_SAMPLES = 128;
    localparam int AW            = 6;
    localparam int W             = 18;

    logic          sys_clk   = 1'b0;
    logic          reset     = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_last  = 1'b0;
    logic [AW-1:0] cfg_addr  = '0;
    logic [W-1:0]  cfg_data  = '0;
    logic          cfg_ready;
    logic          sam_clk_en;
    logic          coef_wr_en;
    logic [AW-1:0] coef_wr_addr;
    logic [W-1:0]  coef_wr_data;
    logic          bank_sel;
    logic          out_valid;
    logic          busy;
    logic          cfg_err;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int            due;
        bit            is_err;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } exp_t;

    exp_t exp_q[$];

    fir_coef_sched #(.DIV(DIV)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_last     (cfg_last),
        .sam_clk_en   (sam_clk_en),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .bank_sel     (bank_sel),
        .out_valid    (out_valid),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: edges since reset, load progress, pending swap and samples left to flush.
    int m_cycles     = 0;
    bit m_loading    = 1'b0;
    int m_next       = 0;
    bit m_pending    = 1'b0;
    int m_flush_left = FLUSH_SAMPLES;
    bit m_bank       = 1'b0;
    bit m_valid      = 1'b0;

    function automatic bit m_sam();
        return (m_cycles > 0) && (m_cycles % DIV == 0);
    endfunction

    function automatic bit m_ready();
        return !m_pending && (m_flush_left == 0);
    endfunction

    function automatic bit m_busy();
        return m_loading || m_pending || (m_flush_left > 0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            m_cycles     <= 0;
            m_loading    <= 1'b0;
            m_next       <= 0;
            m_pending    <= 1'b0;
            m_flush_left <= FLUSH_SAMPLES;
            m_bank       <= 1'b0;
            m_valid      <= 1'b0;
            exp_q.delete();
        end else begin
            m_cycles <= m_cycles + 1;
            if (cfg_valid && m_ready()) begin
                if (!m_loading) begin
                    if (cfg_addr == '0) begin
                        exp_q.push_back('{m_cycles + 1, 1'b0, cfg_addr, cfg_data});
                        m_loading <= 1'b1;
                        m_next    <= 1;
                    end else begin
                        exp_q.push_back('{m_cycles + 1, 1'b1, '0, '0});
                    end
                end else if (int'(cfg_addr) == m_next &&
                             (cfg_last == (int'(cfg_addr) == NTAPS - 1))) begin
                    exp_q.push_back('{m_cycles + 1, 1'b0, cfg_addr, cfg_data});
                    if (cfg_last) begin
                        m_loading <= 1'b0;
                        m_pending <= 1'b1;
                    end else begin
                        m_next <= m_next + 1;
                    end
                end else begin
                    exp_q.push_back('{m_cycles + 1, 1'b1, '0, '0});
                    m_loading <= 1'b0;
                end
            end else if (m_pending && m_sam()) begin
                m_bank       <= !m_bank;
                m_valid      <= 1'b0;
                m_pending    <= 1'b0;
                m_flush_left <= FLUSH_SAMPLES;
            end else if (m_flush_left > 0 && m_sam()) begin
                m_flush_left <= m_flush_left - 1;
                if (m_flush_left == 1) m_valid <= 1'b1;
            end
        end
    end

    // Monitor: pops whatever the model scheduled for this cycle and compares the DUT.
    always @(negedge sys_clk) begin
        if (reset) begin
            exp_t          it;
            bit            ew;
            bit            ee;
            logic [AW-1:0] ea;
            logic [W-1:0]  ed;
            ew = 1'b0;
            ee = 1'b0;
            ea = '0;
            ed = '0;
            while (exp_q.size() > 0 && exp_q[0].due < m_cycles) begin
                it = exp_q.pop_front();
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL missed_event: due %0d, now %0d", it.due, m_cycles);
            end
            if (exp_q.size() > 0 && exp_q[0].due == m_cycles) begin
                it = exp_q.pop_front();
                ew = !it.is_err;
                ee = it.is_err;
                ea = it.addr;
                ed = it.data;
            end
            checkOutput("coef_wr_en", 32'(coef_wr_en), 32'(ew));
            checkOutput("cfg_err", 32'(cfg_err), 32'(ee));
            if (ew && coef_wr_en) begin
                checkOutput("coef_wr_addr", 32'(coef_wr_addr), 32'(ea));
                checkOutput("coef_wr_data", 32'(coef_wr_data), 32'(ed));
            end
            checkOutput("sam_clk_en", 32'(sam_clk_en), 32'(m_sam()));
            checkOutput("bank_sel", 32'(bank_sel), 32'(m_bank));
            checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("busy", 32'(busy), 32'(m_busy()));
            checkOutput("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
        end
    end

    task automatic applyStimulus(input int addr, input logic [W-1:0] data, input bit last,
                                 input bit random_valid);
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        while (!done) begin
            @(negedge sys_clk);
            cfg_addr  = AW'(addr);
            cfg_data  = data;
            cfg_last  = last;
            cfg_valid = random_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cfg_valid && cfg_ready) done = 1'b1;
            guard++;
            if (!done && guard > 50) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL beat_accept_timeout: addr %0d not accepted, required within 50 cycles", addr);
                done = 1'b1;
            end
        end
    endtask

    task automatic busIdle();
        @(negedge sys_clk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (busy && n < limit);
        checkOutput(name, 32'(busy), 32'(0));
    endtask

    task automatic loadFullSet(input bit random_valid, input bit addr_data);
        for (int a = 0; a < NTAPS; a++) begin
            applyStimulus(a, addr_data ? W'(a + 1000) : W'($urandom), a == NTAPS - 1, random_valid);
        end
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        reset = 1'b1;
        waitIdle("initial_flush_done", 4 * DIV * FLUSH_SAMPLES);
        checkOutput("initial_out_valid", 32'(out_valid), 32'(1));
        checkOutput("initial_bank", 32'(bank_sel), 32'(0));

        loadFullSet(1'b0, 1'b1);
        busIdle();
        waitIdle("load_flush_done", 4 * DIV * FLUSH_SAMPLES);
        checkOutput("bank_after_load", 32'(bank_sel), 32'(1));

        applyStimulus(0, W'($urandom), 1'b0, 1'b0);
        applyStimulus(1, W'($urandom), 1'b0, 1'b0);
        applyStimulus(3, W'($urandom), 1'b0, 1'b0);
        busIdle();
        repeat (5) @(negedge sys_clk);

        for (int a = 0; a <= 30; a++) applyStimulus(a, W'($urandom), a == 30, 1'b0);
        busIdle();
        repeat (5) @(negedge sys_clk);
        for (int a = 0; a < NTAPS; a++) applyStimulus(a, W'($urandom), 1'b0, 1'b0);
        busIdle();
        repeat (10) @(negedge sys_clk);
        checkOutput("bank_after_errors", 32'(bank_sel), 32'(1));

        loadFullSet(1'b1, 1'b0);
        repeat (300) begin
            @(negedge sys_clk);
            cfg_valid = 1'b1;
            cfg_addr  = AW'($urandom_range(0, NTAPS - 1));
            cfg_data  = W'($urandom);
            cfg_last  = 1'($urandom_range(0, 1));
        end
        busIdle();
        waitIdle("random_flush_done", 4 * DIV * FLUSH_SAMPLES);
        checkOutput("bank_after_random", 32'(bank_sel), 32'(0));

        loadFullSet(1'b0, 1'b0);
        busIdle();
        repeat (60) @(negedge sys_clk);
        @(posedge sys_clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_sam_clk_en", 32'(sam_clk_en), 32'(0));
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'(0));
        checkOutput("rst_coef_wr_en", 32'(coef_wr_en), 32'(0));
        checkOutput("rst_coef_wr_addr", 32'(coef_wr_addr), 32'(0));
        checkOutput("rst_coef_wr_data", 32'(coef_wr_data), 32'(0));
        checkOutput("rst_bank_sel", 32'(bank_sel), 32'(0));
        checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("rst_cfg_err", 32'(cfg_err), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(1));
        repeat (3) @(negedge sys_clk);
        reset = 1'b1;
        waitIdle("post_reset_flush_done", 4 * DIV * FLUSH_SAMPLES);
        checkOutput("post_reset_out_valid", 32'(out_valid), 32'(1));

        repeat (4) @(negedge sys_clk);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fir_coef_sched.md
Name: fir_coef_sched

Overview:
- Controller for the 121-tap symmetric FIR datapath, which has 61 unique coefficients and an 18-bit 2s16 sample path.
- Generates the sample clock enable (sam_clk_en) from sys_clk.
- Accepts a new coefficient set over a valid/ready stream into the FIR's shadow coefficient bank, then swaps banks on a sample boundary.
- Holds out_valid low while the delay line and adder tree flush, so downstream never sees mixed-coefficient output.

Parameters:
WIDTH, 18, coefficient/sample width (coefficients 0s18 signed)
NTAPS, 61, unique coefficients per set (folded symmetric filter)
ADDR_W, 6, coefficient address width (ceil(log2(NTAPS)))
DIV, 4, sys_clk cycles per sample; legal range is 2 or more
FLUSH_SAMPLES, 128, sam_clk_en pulses to flush (121 delay line + 7 tree levels)

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cfg_valid  in  1  coefficient beat valid
cfg_ready  out  1  block can accept beat
cfg_addr  in  ADDR_W  coefficient index of beat
cfg_data  in  WIDTH  signed coefficient value
cfg_last  in  1  final beat of set
sam_clk_en  out  1  one-cycle sample enable to FIR
coef_wr_en  out  1  shadow bank write strobe
coef_wr_addr  out  ADDR_W  shadow bank write address
coef_wr_data  out  WIDTH  shadow bank write data
bank_sel  out  1  active coefficient bank (FIR reads bank bank_sel)
out_valid  out  1  FIR output y is trustworthy
busy  out  1  high in any state except IDLE
cfg_err  out  1  one-cycle pulse on a malformed set

Behaviour:
- Reset (asserted low, async) values: div counter 0, sam_clk_en 0, cfg_ready 0, coef_wr_en 0, coef_wr_addr 0, coef_wr_data 0, bank_sel 0, out_valid 0, cfg_err 0, beat counter 0. State goes to FLUSH with flush counter = FLUSH_SAMPLES, busy 1.
- Divider:
  - Counter runs 0..DIV-1 continuously and is independent of FSM state.
  - sam_clk_en is registered and is high in the cycle after the counter equals DIV-1, giving exactly one pulse per DIV cycles.
  - First pulse occurs at cycle DIV after reset release.
- States: IDLE, LOAD, ARMED, FLUSH.
- Accept rule: a beat is accepted when cfg_valid and cfg_ready are both high. cfg_ready = (state == IDLE or LOAD).
- IDLE:
  - Accepted beat with cfg_addr=0 moves to LOAD and sets beat counter to 1.
  - Accepted beat with cfg_addr != 0 pulses cfg_err and stays in IDLE.
- LOAD:
  - An accepted beat must satisfy cfg_addr == beat counter.
  - If cfg_last is high, the beat must also satisfy cfg_addr == NTAPS-1, and the state moves to ARMED.
  - Any violation pulses cfg_err, returns to IDLE, and leaves bank_sel unchanged. The shadow bank may be partially written, which is harmless.
  - cfg_addr == NTAPS-1 without cfg_last is also a violation.
- Write port: each accepted, non-erroring beat produces coef_wr_en=1 in the next cycle, carrying the registered addr/data. The write targets bank ~bank_sel.
- ARMED:
  - cfg_ready is 0.
  - On the first cycle with sam_clk_en=1, bank_sel toggles at that edge, out_valid drops to 0, the flush counter loads FLUSH_SAMPLES, and the state moves to FLUSH.
  - The FIR therefore processes the following sample with new coefficients.
- FLUSH:
  - Counter decrements on each sam_clk_en.
  - When it reaches 0: out_valid goes to 1 at the same edge and the state goes to IDLE.
- out_valid is 0 from reset until the first flush completes.
- Simultaneous events:
  - sam_clk_en in the same cycle ARMED is entered does not swap; the swap waits for the next pulse.
  - cfg_valid outside IDLE/LOAD is ignored (not accepted, no error).
- Reset asserted mid-LOAD, ARMED or FLUSH aborts immediately to the reset values above; bank_sel returns to 0.
- No arithmetic on coefficients: cfg_data is passed through unchanged.

Decomposition:
- Package fir_sched_pkg holds: the state enumeration (IDLE/LOAD/ARMED/FLUSH, 2-bit encoding); constants NTAPS, WIDTH, ADDR_W; and the flush-width constant ceil(log2(FLUSH_SAMPLES+1)).
- One sub-module, sam_en_gen: parameter DIV, ports sys_clk/reset/sam_clk_en, implementing the divider only.

Test Plan:
- Reset release, DIV=4: sam_clk_en pulses at cycles 4, 8, 12…; out_valid rises at the edge of the 128th pulse; bank_sel=0 throughout; busy drops the same edge.
- Load 61 beats, addr 0..60, last on 60, data=addr+1000, with cfg_valid held high: 61 coef_wr_en strobes each one cycle after acceptance, with matching addr/data; state ARMED; bank_sel flips to 1 on the next sam_clk_en; out_valid 0 for exactly 128 pulses, then 1.
- Beat sequence 0,1,3: cfg_err pulses on the addr-3 acceptance; return to IDLE; no coef_wr_en for addr 3; bank_sel unchanged; out_valid stays 1.
- cfg_last on addr 30: cfg_err pulse, IDLE, no swap. Separately, addr 60 without last: cfg_err pulse.
- cfg_valid toggled randomly, 50% duty, during a full load: all 61 beats written in order and swap occurs. cfg_valid held high during ARMED/FLUSH: cfg_ready=0, no writes, no errors.
- reset pulsed low mid-FLUSH after a swap: all outputs return to reset values asynchronously (bank_sel=0, out_valid=0); a full 128-pulse flush reruns before out_valid=1.
